one_net_rx: RTL

- Receive end of a single-wire serial net: samples one asynchronous input line and deserialises UART-style frames into parallel words.
- Frame format: idle-high line, one low start bit, DATA_BITS data bits LSB first, one high stop bit.
- Presents each received word on a valid/ready output port.
- Flags framing errors and overruns; pairs with any single-net driver in the test designs.

---
 rtl/one_net_rx.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/one_net_rx.sv
// rtl/one_net_rx.sv - single-wire UART-style frame receiver with valid/ready word output
// Optional even-parity bit and parity_err output enabled by ONE_NET_RX_PARITY_EN.
module one_net_rx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun
`ifdef ONE_NET_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CC_W = $clog2(CLKS_PER_BIT);
    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [CC_W-1:0] CC_LAST      = CC_W'(CLKS_PER_BIT - 1);
    localparam logic [CC_W-1:0] CC_HALF_LAST = CC_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BC_W-1:0] BC_LAST      = BC_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef ONE_NET_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q, state_d;
    logic                  a_meta_q, s_q;
    logic [CC_W-1:0]       cc_q, cc_d;
    logic [BC_W-1:0]       bc_q, bc_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  done;
    logic                  handshake;
`ifdef ONE_NET_RX_PARITY_EN
    logic                  par_q, par_d;
    logic                  parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_meta_q <= 1'b1;
            s_q      <= 1'b1;
        end else begin
            a_meta_q <= a;
            s_q      <= a_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cc_q        <= '0;
            bc_q        <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef ONE_NET_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cc_q        <= cc_d;
            bc_q        <= bc_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
`ifdef ONE_NET_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Bit sampling FSM; cc is re-zeroed at each mid-bit so later samples land mid-bit too.
    always_comb begin
        state_d     = state_q;
        cc_d        = cc_q;
        bc_d        = bc_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        done        = 1'b0;
`ifdef ONE_NET_RX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!s_q) begin
                    cc_d    = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cc_q == CC_HALF_LAST) begin
                    if (s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cc_d    = '0;
                        bc_d    = '0;
                        state_d = S_DATA;
                    end
                end else begin
                    cc_d = cc_q + CC_W'(1);
                end
            end
            S_DATA: begin
                if (cc_q == CC_LAST) begin
                    // Shifting in at the MSB leaves the first (LSB) bit at bit 0 after DATA_BITS shifts.
                    shift_d = {s_q, shift_q[DATA_BITS-1:1]};
                    cc_d    = '0;
                    if (bc_q == BC_LAST) begin
`ifdef ONE_NET_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bc_d = bc_q + BC_W'(1);
                    end
                end else begin
                    cc_d = cc_q + CC_W'(1);
                end
            end
`ifdef ONE_NET_RX_PARITY_EN
            S_PARITY: begin
                if (cc_q == CC_LAST) begin
                    par_d   = s_q;
                    cc_d    = '0;
                    state_d = S_STOP;
                end else begin
                    cc_d = cc_q + CC_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cc_q == CC_LAST) begin
                    cc_d = '0;
                    if (s_q) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cc_d = cc_q + CC_W'(1);
                end
            end
            S_BREAK: begin
                if (s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign handshake = valid_q & ready;

    // A completion coinciding with a handshake refills the buffer without an overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef ONE_NET_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (handshake) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (done) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
`ifdef ONE_NET_RX_PARITY_EN
                parity_err_d = ^{shift_q, par_q};
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
`ifdef ONE_NET_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
